// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: coin codes, denominations, FSM states.
package vend_pkg;
  localparam logic [4:0] COIN_5   = 5'b00001;
  localparam logic [4:0] COIN_10  = 5'b00010;
  localparam logic [4:0] COIN_20  = 5'b00100;
  localparam logic [4:0] COIN_50  = 5'b01000;
  localparam logic [4:0] COIN_100 = 5'b10000;

  localparam logic [6:0] VAL_5   = 7'd5;
  localparam logic [6:0] VAL_10  = 7'd10;
  localparam logic [6:0] VAL_20  = 7'd20;
  localparam logic [6:0] VAL_50  = 7'd50;
  localparam logic [6:0] VAL_100 = 7'd100;

  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_VEND, ST_CHANGE} state_e;

  // Non-one-hot codes map to 0 so callers can add blindly.
  function automatic logic [6:0] coin_value(input logic [4:0] c);
    case (c)
      COIN_5:   return VAL_5;
      COIN_10:  return VAL_10;
      COIN_20:  return VAL_20;
      COIN_50:  return VAL_50;
      COIN_100: return VAL_100;
      default:  return 7'd0;
    endcase
  endfunction
endpackage

// File: rtl/vend_core_gen_change_dispenser.sv
// Greedy change coin selection and valid/ready handshake toward the coin dispenser.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic                active_i,
  input  logic [CREDIT_W-1:0] balance_i,
  input  logic                ready_i,
  output logic                valid_o,
  output logic [4:0]          coin_o,
  output logic                fire_o,
  output logic [CREDIT_W-1:0] dec_o
);
  // Offer follows the registered balance, so it stays put until a transfer lands.
  always_comb begin
    coin_o = '0;
    if (active_i) begin
      if      (balance_i >= CREDIT_W'(100)) coin_o = COIN_100;
      else if (balance_i >= CREDIT_W'(50))  coin_o = COIN_50;
      else if (balance_i >= CREDIT_W'(20))  coin_o = COIN_20;
      else if (balance_i >= CREDIT_W'(10))  coin_o = COIN_10;
      else if (balance_i >= CREDIT_W'(5))   coin_o = COIN_5;
    end
  end

  assign valid_o = active_i;
  assign fire_o  = active_i & ready_i;
  assign dec_o   = CREDIT_W'(coin_value(coin_o));
endmodule

// File: rtl/vend_core_gen.sv
// Vending controller: credit, selection check, vend, stock counters and change return.
module vend_core_gen
  import vend_pkg::*;
#(
  parameter  int NUM_PRODUCTS = 10,
  parameter  int QTY_W        = 4,
  parameter  int CREDIT_W     = 8,
  parameter  int MAX_CREDIT   = 250,
  parameter  int AUTO_CHANGE  = 1,
  localparam int SEL_W        = $clog2(NUM_PRODUCTS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             coin_valid,
  input  logic [4:0]                       coin,
  input  logic                             sel_valid,
  input  logic [SEL_W-1:0]                 sel_code,
  input  logic                             refund,
  input  logic [NUM_PRODUCTS*CREDIT_W-1:0] price_of_all,
  input  logic                             restock_valid,
  input  logic [SEL_W-1:0]                 restock_product,
  input  logic [QTY_W-1:0]                 restock_qty,
  output logic [CREDIT_W-1:0]              balance,
  output logic                             vend_valid,
  output logic [SEL_W-1:0]                 vend_product,
  output logic                             invalid_coin,
  output logic                             max_balance,
  output logic                             bad_select,
  output logic                             no_stock,
  output logic                             low_credit,
  output logic [NUM_PRODUCTS-1:0]          stock_empty,
  output logic                             coin_out_valid,
  output logic [4:0]                       coin_out,
  input  logic                             coin_out_ready,
  output logic                             busy
);
  localparam logic [CREDIT_W:0]   MAX_C   = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] MIN_CHG = CREDIT_W'(5);
  localparam logic [QTY_W+1:0]    QMAX    = (QTY_W+2)'((1 << QTY_W) - 1);

  state_e                                 state_q;
  logic [CREDIT_W-1:0]                    bal_q, price_q, dec, bal_idle, bal_chg;
  logic [SEL_W-1:0]                       sel_q;
  logic                                   pend_q;
  logic [QTY_W-1:0]                       stock_q [NUM_PRODUCTS];
  logic [NUM_PRODUCTS-1:0][CREDIT_W-1:0]  price_tbl;
  logic [CREDIT_W:0]                      coin_sum;
  logic                                   coin_onehot, coin_fits, fire, vend_go, refund_req, in_change;

  assign price_tbl   = price_of_all;
  assign coin_onehot = $onehot(coin);
  assign coin_sum    = {1'b0, bal_q} + (CREDIT_W+1)'(coin_value(coin));
  assign coin_fits   = coin_sum <= MAX_C;
  assign bal_idle    = (coin_valid && coin_onehot && coin_fits) ? coin_sum[CREDIT_W-1:0] : bal_q;
  assign refund_req  = refund | pend_q;
  assign vend_go     = (state_q == ST_CHECK) && (stock_q[sel_q] != '0) && (bal_q >= price_q);
  assign bal_chg     = fire ? bal_q - dec : bal_q;
  assign in_change   = (state_q == ST_CHANGE);
  assign balance     = bal_q;
  assign busy        = (state_q != ST_IDLE);

  change_dispenser #(.CREDIT_W(CREDIT_W)) u_chg (
    .active_i  (in_change),
    .balance_i (bal_q),
    .ready_i   (coin_out_ready),
    .valid_o   (coin_out_valid),
    .coin_o    (coin_out),
    .fire_o    (fire),
    .dec_o     (dec)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      bal_q        <= '0;
      price_q      <= '0;
      sel_q        <= '0;
      pend_q       <= 1'b0;
      vend_valid   <= 1'b0;
      vend_product <= '0;
      invalid_coin <= 1'b0;
      max_balance  <= 1'b0;
      bad_select   <= 1'b0;
      no_stock     <= 1'b0;
      low_credit   <= 1'b0;
    end else begin
      vend_valid   <= 1'b0;
      invalid_coin <= coin_valid && (state_q != ST_IDLE || !coin_onehot);
      max_balance  <= 1'b0;
      bad_select   <= 1'b0;
      no_stock     <= 1'b0;
      low_credit   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          bal_q       <= bal_idle;
          max_balance <= coin_valid && coin_onehot && !coin_fits;
          pend_q      <= 1'b0;
          // A refund request swallows a same-cycle selection even when there is nothing to return.
          if (refund_req) begin
            if (bal_idle >= MIN_CHG) state_q <= ST_CHANGE;
          end else if (sel_valid) begin
            if (int'(sel_code) >= NUM_PRODUCTS) bad_select <= 1'b1;
            else begin
              sel_q   <= sel_code;
              price_q <= price_tbl[sel_code];
              state_q <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          pend_q <= pend_q | refund;
          if (stock_q[sel_q] == '0) begin
            no_stock <= 1'b1;
            state_q  <= ST_IDLE;
          end else if (bal_q < price_q) begin
            low_credit <= 1'b1;
            state_q    <= ST_IDLE;
          end else begin
            bal_q        <= bal_q - price_q;
            vend_valid   <= 1'b1;
            vend_product <= sel_q;
            state_q      <= ST_VEND;
          end
        end
        ST_VEND: begin
          pend_q  <= pend_q | refund;
          state_q <= (AUTO_CHANGE != 0 && bal_q >= MIN_CHG) ? ST_CHANGE : ST_IDLE;
        end
        default: begin
          bal_q <= bal_chg;
          if (bal_chg < MIN_CHG) state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Restock and vend decrement meet in one saturating sum per slot.
  for (genvar i = 0; i < NUM_PRODUCTS; i++) begin : g_stock
    logic [QTY_W+1:0] sum;
    logic             hit_r, hit_v;

    always_comb begin
      hit_r = restock_valid && (int'(restock_product) == i);
      hit_v = vend_go && (int'(sel_q) == i);
      sum   = (QTY_W+2)'(stock_q[i]) + (hit_r ? (QTY_W+2)'(restock_qty) : '0) - (QTY_W+2)'(hit_v);
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset)              stock_q[i] <= '0;
      else if (hit_r || hit_v) stock_q[i] <= (sum > QMAX) ? QMAX[QTY_W-1:0] : sum[QTY_W-1:0];
    end

    assign stock_empty[i] = (stock_q[i] == '0);
  end
endmodule

// File: tb/tb_vend_core_gen.sv
// Scenario tasks plus a randomized run against a transaction-level model of credit, stock and change.
module tb_vend_core_gen;
  localparam int NP = 10, CW = 8, QW = 4, SW = 4;

  logic               clk = 1'b0, reset = 1'b0;
  logic               coin_valid = 1'b0, sel_valid = 1'b0, refund = 1'b0;
  logic [4:0]         coin = '0;
  logic [SW-1:0]      sel_code = '0, restock_product = '0;
  logic [NP*CW-1:0]   price_of_all = '0;
  logic               restock_valid = 1'b0, coin_out_ready = 1'b0;
  logic [QW-1:0]      restock_qty = '0;
  logic [CW-1:0]      balance;
  logic               vend_valid, invalid_coin, max_balance, bad_select, no_stock, low_credit;
  logic [SW-1:0]      vend_product;
  logic [NP-1:0]      stock_empty;
  logic               coin_out_valid, busy;
  logic [4:0]         coin_out;

  int checks = 0, failures = 0;
  int m_bal;
  int m_stock [NP];
  int m_price [NP];
  int denoms [5] = '{100, 50, 20, 10, 5};

  vend_core_gen dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin(coin),
    .sel_valid(sel_valid), .sel_code(sel_code), .refund(refund),
    .price_of_all(price_of_all), .restock_valid(restock_valid),
    .restock_product(restock_product), .restock_qty(restock_qty),
    .balance(balance), .vend_valid(vend_valid), .vend_product(vend_product),
    .invalid_coin(invalid_coin), .max_balance(max_balance), .bad_select(bad_select),
    .no_stock(no_stock), .low_credit(low_credit), .stock_empty(stock_empty),
    .coin_out_valid(coin_out_valid), .coin_out(coin_out),
    .coin_out_ready(coin_out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] code_of(input int v);
    case (v)
      5:       return 5'b00001;
      10:      return 5'b00010;
      20:      return 5'b00100;
      50:      return 5'b01000;
      100:     return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic int val_of(input logic [4:0] c);
    for (int i = 0; i < 5; i++) if (code_of(denoms[i]) == c) return denoms[i];
    return 0;
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic put_coin(input logic [4:0] c);
    coin_valid = 1'b1; coin = c; tick; coin_valid = 1'b0; coin = '0;
  endtask

  task automatic start_sel(input int p);
    sel_valid = 1'b1; sel_code = SW'(p); tick; sel_valid = 1'b0;
  endtask

  task automatic set_price(input int p, input int v);
    price_of_all[p*CW +: CW] = CW'(v); m_price[p] = v;
  endtask

  task automatic restock_now(input int p, input int q);
    restock_valid = 1'b1; restock_product = SW'(p); restock_qty = QW'(q);
    tick; restock_valid = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b0; #2; reset = 1'b1; tick;
    m_bal = 0;
    for (int i = 0; i < NP; i++) m_stock[i] = 0;
  endtask

  // Expects to be called in a CHANGE cycle; rnd=0 uses the ready pattern 1,0,1,1,1...
  task automatic collect_change(input int bal0, input bit rnd, output int resid);
    int q[$];
    int b, k;
    bit r;
    b = bal0;
    foreach (denoms[i]) while (b >= denoms[i]) begin q.push_back(denoms[i]); b -= denoms[i]; end
    resid = b;
    k = 0;
    while (q.size() > 0 && k < 300) begin
      checks++;
      if (coin_out_valid !== 1'b1 || coin_out !== code_of(q[0])) begin
        failures++;
        $display("FAIL change_coin got valid=%0b coin=%b exp coin=%b", coin_out_valid, coin_out, code_of(q[0]));
      end
      r = rnd ? 1'($urandom_range(0, 1)) : (k != 1);
      coin_out_ready = r; tick; coin_out_ready = 1'b0;
      if (r) void'(q.pop_front());
      k++;
    end
    checks++;
    if (q.size() != 0) begin failures++; $display("FAIL change_timeout left=%0d exp=0", q.size()); end
    checks++;
    if (coin_out_valid !== 1'b0 || busy !== 1'b0 || int'(balance) !== resid) begin
      failures++;
      $display("FAIL change_end got valid=%0b busy=%0b bal=%0d exp 0 0 %0d", coin_out_valid, busy, balance, resid);
    end
  endtask

  task automatic test_reset;
    checks++; if (balance !== '0) begin failures++; $display("FAIL reset_balance got=%0d exp=0", balance); end
    checks++; if (stock_empty !== {NP{1'b1}}) begin failures++; $display("FAIL reset_stock_empty got=%b exp all ones", stock_empty); end
    checks++; if (busy !== 1'b0 || coin_out_valid !== 1'b0 || coin_out !== 5'b0) begin
      failures++; $display("FAIL reset_outputs got busy=%0b cov=%0b co=%b exp 0", busy, coin_out_valid, coin_out); end
    checks++; if ({vend_valid, invalid_coin, max_balance, bad_select, no_stock, low_credit} !== 6'b0) begin
      failures++; $display("FAIL reset_pulses got=%b exp=0", {vend_valid, invalid_coin, max_balance, bad_select, no_stock, low_credit}); end
  endtask

  task automatic test_vend_basic;
    set_price(3, 35); restock_now(3, 2);
    put_coin(code_of(20)); put_coin(code_of(20));
    checks++; if (int'(balance) !== 40) begin failures++; $display("FAIL vb_credit got=%0d exp=40", balance); end
    start_sel(3);
    checks++; if (busy !== 1'b1 || vend_valid !== 1'b0) begin failures++; $display("FAIL vb_check got busy=%0b vend=%0b exp 1 0", busy, vend_valid); end
    tick;
    checks++; if (vend_valid !== 1'b1 || int'(vend_product) !== 3 || int'(balance) !== 5) begin
      failures++; $display("FAIL vb_vend got vend=%0b prod=%0d bal=%0d exp 1 3 5", vend_valid, vend_product, balance); end
    tick;
    checks++; if (vend_valid !== 1'b0 || coin_out_valid !== 1'b1 || coin_out !== 5'b00001) begin
      failures++; $display("FAIL vb_offer got vend=%0b cov=%0b co=%b exp 0 1 00001", vend_valid, coin_out_valid, coin_out); end
    coin_out_ready = 1'b1; tick; coin_out_ready = 1'b0;
    checks++; if (balance !== '0 || coin_out_valid !== 1'b0 || busy !== 1'b0 || stock_empty[3] !== 1'b0) begin
      failures++; $display("FAIL vb_done got bal=%0d cov=%0b busy=%0b empty3=%0b exp 0 0 0 0", balance, coin_out_valid, busy, stock_empty[3]); end
  endtask

  task automatic test_coin_errors;
    int r;
    put_coin(code_of(100)); put_coin(code_of(100)); put_coin(code_of(20)); put_coin(code_of(20));
    checks++; if (int'(balance) !== 240) begin failures++; $display("FAIL ce_240 got=%0d exp=240", balance); end
    put_coin(code_of(20));
    checks++; if (max_balance !== 1'b1 || int'(balance) !== 240) begin
      failures++; $display("FAIL ce_max got flag=%0b bal=%0d exp 1 240", max_balance, balance); end
    tick;
    checks++; if (max_balance !== 1'b0) begin failures++; $display("FAIL ce_max_pulse got=%0b exp=0", max_balance); end
    put_coin(5'b00011);
    checks++; if (invalid_coin !== 1'b1 || int'(balance) !== 240) begin
      failures++; $display("FAIL ce_invalid got flag=%0b bal=%0d exp 1 240", invalid_coin, balance); end
    refund = 1'b1; tick; refund = 1'b0;
    collect_change(240, 1'b1, r);
  endtask

  task automatic test_select_errors;
    put_coin(code_of(10));
    start_sel(3); tick;
    checks++; if (low_credit !== 1'b1 || vend_valid !== 1'b0 || int'(balance) !== 10 || busy !== 1'b0) begin
      failures++; $display("FAIL se_low got low=%0b vend=%0b bal=%0d busy=%0b exp 1 0 10 0", low_credit, vend_valid, balance, busy); end
    start_sel(5); tick;
    checks++; if (no_stock !== 1'b1 || low_credit !== 1'b0 || int'(balance) !== 10) begin
      failures++; $display("FAIL se_nostock got ns=%0b low=%0b bal=%0d exp 1 0 10", no_stock, low_credit, balance); end
    start_sel(12);
    checks++; if (bad_select !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL se_bad got bad=%0b busy=%0b exp 1 0", bad_select, busy); end
  endtask

  task automatic test_refund_pending;
    int r;
    start_sel(3);
    refund = 1'b1; tick; refund = 1'b0;
    checks++; if (low_credit !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL rp_low got low=%0b busy=%0b exp 1 0", low_credit, busy); end
    tick;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rp_serviced got busy=%0b exp=1", busy); end
    collect_change(10, 1'b0, r);
  endtask

  task automatic test_refund_stall;
    int r;
    put_coin(code_of(100)); put_coin(code_of(50)); put_coin(code_of(20)); put_coin(code_of(10)); put_coin(code_of(5));
    checks++; if (int'(balance) !== 185) begin failures++; $display("FAIL rs_185 got=%0d exp=185", balance); end
    refund = 1'b1; tick; refund = 1'b0;
    put_coin(code_of(5));
    checks++; if (invalid_coin !== 1'b1 || int'(balance) !== 185 || coin_out !== 5'b10000) begin
      failures++; $display("FAIL rs_coin_in_change got inv=%0b bal=%0d co=%b exp 1 185 10000", invalid_coin, balance, coin_out); end
    collect_change(185, 1'b0, r);
  endtask

  task automatic test_restock_sat;
    set_price(3, 50); restock_now(3, 15);
    put_coin(code_of(50));
    start_sel(3);
    restock_valid = 1'b1; restock_product = 4'd3; restock_qty = 4'd4; tick; restock_valid = 1'b0;
    checks++; if (vend_valid !== 1'b1 || balance !== '0) begin
      failures++; $display("FAIL sat_vend got vend=%0b bal=%0d exp 1 0", vend_valid, balance); end
    tick;
    set_price(3, 0);
    for (int k = 1; k <= 15; k++) begin
      start_sel(3); tick;
      checks++; if (vend_valid !== 1'b1) begin failures++; $display("FAIL sat_drain%0d got vend=%0b exp=1", k, vend_valid); end
      tick;
      if (k >= 14) begin
        checks++; if (stock_empty[3] !== (k == 15)) begin
          failures++; $display("FAIL sat_empty%0d got=%0b exp=%0b", k, stock_empty[3], k == 15); end
      end
    end
    start_sel(3); tick;
    checks++; if (no_stock !== 1'b1) begin failures++; $display("FAIL sat_final got ns=%0b exp=1", no_stock); end
  endtask

  task automatic test_random;
    int op, p, q, v;
    logic [4:0] c;
    logic [NP-1:0] ev;
    bit e_inv, e_max, e_ns, e_lc, e_v;
    do_reset;
    for (int i = 0; i < NP; i++) set_price(i, $urandom_range(0, 120));
    repeat (80) begin
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        if ($urandom_range(0, 7) == 0) c = 5'($urandom_range(0, 31));
        else c = code_of(denoms[$urandom_range(0, 4)]);
        v = val_of(c);
        put_coin(c);
        e_inv = ($countones(c) != 1);
        e_max = !e_inv && (m_bal + v > 250);
        if (!e_inv && !e_max) m_bal += v;
        checks++; if (invalid_coin !== e_inv || max_balance !== e_max || int'(balance) !== m_bal) begin
          failures++; $display("FAIL rnd_coin got inv=%0b max=%0b bal=%0d exp %0b %0b %0d", invalid_coin, max_balance, balance, e_inv, e_max, m_bal); end
      end else if (op <= 5) begin
        p = $urandom_range(0, NP-1); q = $urandom_range(0, 15);
        restock_now(p, q);
        m_stock[p] = (m_stock[p] + q > 15) ? 15 : m_stock[p] + q;
        for (int i = 0; i < NP; i++) ev[i] = (m_stock[i] == 0);
        checks++; if (stock_empty !== ev) begin failures++; $display("FAIL rnd_restock got=%b exp=%b", stock_empty, ev); end
      end else if (op == 6) begin
        refund = 1'b1; tick; refund = 1'b0;
        if (m_bal >= 5) collect_change(m_bal, 1'b1, m_bal);
        else begin
          checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rnd_refund_noop got busy=%0b exp=0", busy); end
        end
      end else begin
        p = $urandom_range(0, NP+1);
        start_sel(p);
        if (p >= NP) begin
          checks++; if (bad_select !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL rnd_bad got bad=%0b busy=%0b exp 1 0", bad_select, busy); end
        end else begin
          tick;
          e_ns = (m_stock[p] == 0);
          e_lc = !e_ns && (m_bal < m_price[p]);
          e_v  = !e_ns && !e_lc;
          if (e_v) begin m_bal -= m_price[p]; m_stock[p]--; end
          checks++; if (vend_valid !== e_v || no_stock !== e_ns || low_credit !== e_lc || int'(balance) !== m_bal ||
                        (e_v && int'(vend_product) !== p)) begin
            failures++; $display("FAIL rnd_sel p=%0d got v=%0b ns=%0b lc=%0b bal=%0d prod=%0d exp %0b %0b %0b %0d",
                                 p, vend_valid, no_stock, low_credit, balance, vend_product, e_v, e_ns, e_lc, m_bal); end
          if (e_v) begin
            tick;
            if (m_bal >= 5) collect_change(m_bal, 1'b1, m_bal);
            else begin
              checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rnd_vend_idle got busy=%0b exp=0", busy); end
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_dispense;
    put_coin(code_of(100));
    refund = 1'b1; tick; refund = 1'b0;
    checks++; if (coin_out_valid !== 1'b1) begin failures++; $display("FAIL rm_offer got=%0b exp=1", coin_out_valid); end
    #2; reset = 1'b0; #1;
    checks++; if (coin_out_valid !== 1'b0 || coin_out !== 5'b0 || balance !== '0 || busy !== 1'b0 || stock_empty !== {NP{1'b1}}) begin
      failures++; $display("FAIL rm_async got cov=%0b co=%b bal=%0d busy=%0b se=%b exp 0 0 0 0 all ones",
                           coin_out_valid, coin_out, balance, busy, stock_empty); end
    #3; reset = 1'b1; tick;
    checks++; if (balance !== '0 || busy !== 1'b0) begin
      failures++; $display("FAIL rm_after got bal=%0d busy=%0b exp 0 0", balance, busy); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    m_bal = 0;
    for (int i = 0; i < NP; i++) begin m_stock[i] = 0; m_price[i] = 0; end
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    reset = 1'b1;
    tick;
    test_vend_basic;
    test_coin_errors;
    test_select_errors;
    test_refund_pending;
    test_refund_stall;
    test_restock_sat;
    test_random;
    test_reset_mid_dispense;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
